// File: rtl/ex_stage_mc_if.sv
// Execute-stage bundle: ID-side issue handshake, MEM-side result handshake.
// DUT takes the slave view; the driving side takes the master view.
interface ex_stage_mc_if #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3
);
  localparam int SELW = $clog2(NUM_FWD + 1);

  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [XLEN-1:0]         pc_in;
  logic [XLEN-1:0]         rs1_in;
  logic [XLEN-1:0]         rs2_in;
  logic [XLEN-1:0]         imm_in;
  logic [4:0]              op_in;
  logic [2:0]              cmp_op_in;
  logic                    use_pc_a;
  logic                    use_imm_b;
  logic                    is_branch;
  logic                    is_jump;
  logic [SELW-1:0]         fwd_sel_a;
  logic [SELW-1:0]         fwd_sel_b;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         result;
  logic                    br_en;
  logic [XLEN-1:0]         br_target;
  logic [XLEN-1:0]         rs2_fwd;
  logic                    busy;

  modport slave (
    input  flush, in_valid, pc_in, rs1_in, rs2_in, imm_in,
    input  op_in, cmp_op_in, use_pc_a, use_imm_b,
    input  is_branch, is_jump, fwd_sel_a, fwd_sel_b,
    input  fwd_data, out_ready,
    output in_ready, out_valid, result, br_en,
    output br_target, rs2_fwd, busy
  );

  modport master (
    output flush, in_valid, pc_in, rs1_in, rs2_in, imm_in,
    output op_in, cmp_op_in, use_pc_a, use_imm_b,
    output is_branch, is_jump, fwd_sel_a, fwd_sel_b,
    output fwd_data, out_ready,
    input  in_ready, out_valid, result, br_en,
    input  br_target, rs2_fwd, busy
  );
endinterface

// File: rtl/ex_stage_mc.sv
// Handshaked execute stage: 1-cycle ALU/branch, iterative RV32M mul/div.
// Operands are forwarded at accept; mul/div back-pressures ID while busy.
module ex_stage_mc #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3
) (
  input  logic            clk,
  input  logic            reset,
  ex_stage_mc_if.slave    ex
);
  localparam int SELW = $clog2(NUM_FWD + 1);
  localparam int CW   = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DONE, MULDIV} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   dvs;
  logic [2:0]        md_op;
  logic              nq, nr;
  logic [XLEN-1:0]   res_q, tgt_q, st_q;
  logic              br_q;

  function automatic logic [XLEN-1:0] fwd(
    input logic [SELW-1:0]         sel,
    input logic [XLEN-1:0]         rf,
    input logic [NUM_FWD*XLEN-1:0] bus
  );
    fwd = rf;
    for (int k = 1; k <= NUM_FWD; k++)
      if (int'(sel) == k) fwd = bus[(k-1)*XLEN +: XLEN];
  endfunction

  function automatic logic cmp(
    input logic [XLEN-1:0] x,
    input logic [XLEN-1:0] y,
    input logic [2:0]      c
  );
    case (c)
      3'd0:    cmp = x == y;
      3'd1:    cmp = x != y;
      3'd4:    cmp = $signed(x) < $signed(y);
      3'd5:    cmp = $signed(x) >= $signed(y);
      3'd6:    cmp = x < y;
      3'd7:    cmp = x >= y;
      default: cmp = 1'b0;
    endcase
  endfunction

  logic [XLEN-1:0] fa, fb, a, b, ma, mb, alu_res;
  logic [CW-1:0]   sh;
  logic [4:0]      op;
  logic            accept, in_ready;
  logic            is_md, is_div, b_zero, ovf, md_iter;
  logic            sa, sb;

  assign op     = ex.op_in;
  assign fa     = fwd(ex.fwd_sel_a, ex.rs1_in, ex.fwd_data);
  assign fb     = fwd(ex.fwd_sel_b, ex.rs2_in, ex.fwd_data);
  assign a      = ex.use_pc_a  ? ex.pc_in  : fa;
  assign b      = ex.use_imm_b ? ex.imm_in : fb;
  assign sh     = b[CW-1:0];
  assign is_md  = op[4:3] == 2'b10;
  assign is_div = op[4:2] == 3'b101;
  assign b_zero = b == '0;
  assign ovf    = is_div & ~op[0] & (a == SMIN) & (b == '1);
  assign md_iter = is_md & ~(is_div & (b_zero | ovf));
  assign sa = a[XLEN-1] & ((op == 5'd17) | (op == 5'd18) |
                           (op == 5'd20) | (op == 5'd22));
  assign sb = b[XLEN-1] & ((op == 5'd17) | (op == 5'd20) |
                           (op == 5'd22));
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;

  assign in_ready = (state == IDLE) | ((state == DONE) & ex.out_ready);
  assign accept   = ex.in_valid & in_ready & ~ex.flush;

  // single-cycle results, including div-by-zero and signed overflow
  always_comb begin
    alu_res = '0;
    case (op)
      5'd0:  alu_res = a + b;
      5'd1:  alu_res = a - b;
      5'd2:  alu_res = a << sh;
      5'd3:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      5'd4:  alu_res = {{(XLEN-1){1'b0}}, a < b};
      5'd5:  alu_res = a ^ b;
      5'd6:  alu_res = a >> sh;
      5'd7:  alu_res = $signed(a) >>> sh;
      5'd8:  alu_res = a | b;
      5'd9:  alu_res = a & b;
      5'd10: alu_res = b;
      5'd20, 5'd21: alu_res = b_zero ? '1 : a;
      5'd22, 5'd23: alu_res = b_zero ? a : '0;
      default: alu_res = '0;
    endcase
  end

  logic [XLEN:0]     sum, sh_r, diff;
  logic [2*XLEN-1:0] step_nxt, prod;
  logic [XLEN-1:0]   qv, rv, md_res;

  // one shift-add or restoring-divide step, plus final sign fix-up
  always_comb begin
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? dvs : '0};
    sh_r = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff = sh_r - {1'b0, dvs};
    if (!md_op[2])
      step_nxt = {sum, acc[XLEN-1:1]};
    else if (!diff[XLEN])
      step_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      step_nxt = {sh_r[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    prod = nq ? -step_nxt : step_nxt;
    qv   = step_nxt[XLEN-1:0];
    rv   = step_nxt[2*XLEN-1:XLEN];
    case (md_op)
      3'd0:       md_res = prod[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       md_res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5: md_res = nq ? -qv : qv;
      default:    md_res = nr ? -rv : rv;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: flush beats everything, DONE holds until MEM takes it
  always_comb begin
    state_nxt = state;
    if (ex.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:
          if (accept) state_nxt = md_iter ? MULDIV : DONE;
        DONE:
          if (ex.out_ready)
            state_nxt = accept ? (md_iter ? MULDIV : DONE) : IDLE;
        MULDIV:
          if (cnt == CW'(XLEN-1)) state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // datapath registers: load on accept, iterate in MULDIV
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      acc   <= '0;
      dvs   <= '0;
      md_op <= '0;
      nq    <= 1'b0;
      nr    <= 1'b0;
      res_q <= '0;
      tgt_q <= '0;
      st_q  <= '0;
      br_q  <= 1'b0;
    end else if (accept) begin
      br_q  <= ex.is_branch ? cmp(fa, fb, ex.cmp_op_in) : ex.is_jump;
      tgt_q <= ex.pc_in + ex.imm_in;
      st_q  <= fb;
      if (md_iter) begin
        cnt   <= '0;
        md_op <= op[2:0];
        nq    <= sa ^ sb;
        nr    <= sa;
        dvs   <= op[2] ? mb : ma;
        acc   <= {{XLEN{1'b0}}, op[2] ? ma : mb};
      end else begin
        res_q <= alu_res;
      end
    end else if (state == MULDIV && !ex.flush) begin
      acc <= step_nxt;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(XLEN-1)) res_q <= md_res;
    end
  end

  assign ex.in_ready  = in_ready;
  assign ex.out_valid = state == DONE;
  assign ex.busy      = state == MULDIV;
  assign ex.result    = res_q;
  assign ex.br_en     = br_q;
  assign ex.br_target = tgt_q;
  assign ex.rs2_fwd   = st_q;
endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc: ALU, forwarding, mul/div, branch,
// back-pressure, flush and mid-iteration reset.
module tb_ex_stage_mc;
  localparam int XLEN = 32;
  localparam int NF   = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ex_stage_mc_if #(.XLEN(XLEN), .NUM_FWD(NF)) ex_if ();

  ex_stage_mc #(.XLEN(XLEN), .NUM_FWD(NF)) u_dut (
    .clk   (clk),
    .reset (reset),
    .ex    (ex_if)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clr();
    ex_if.flush     = 1'b0;
    ex_if.in_valid  = 1'b0;
    ex_if.pc_in     = '0;
    ex_if.rs1_in    = '0;
    ex_if.rs2_in    = '0;
    ex_if.imm_in    = '0;
    ex_if.op_in     = '0;
    ex_if.cmp_op_in = '0;
    ex_if.use_pc_a  = 1'b0;
    ex_if.use_imm_b = 1'b0;
    ex_if.is_branch = 1'b0;
    ex_if.is_jump   = 1'b0;
    ex_if.fwd_sel_a = '0;
    ex_if.fwd_sel_b = '0;
    ex_if.fwd_data  = '0;
    ex_if.out_ready = 1'b1;
  endtask

  task automatic issue();
    ex_if.in_valid = 1'b1;
    step();
    ex_if.in_valid = 1'b0;
  endtask

  task automatic alu(input string tag, input logic [4:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    clr();
    ex_if.op_in  = op;
    ex_if.rs1_in = a;
    ex_if.rs2_in = b;
    issue();
    chk({tag, "_v"}, ex_if.out_valid, 1);
    chk(tag, ex_if.result, exp);
    step();
  endtask

  task automatic md(input string tag, input logic [4:0] op,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp);
    int n;
    clr();
    ex_if.op_in  = op;
    ex_if.rs1_in = a;
    ex_if.rs2_in = b;
    issue();
    chk({tag, "_busy"}, ex_if.busy, 1);
    chk({tag, "_rdy"}, ex_if.in_ready, 0);
    n = 1;
    while (!ex_if.out_valid && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, 33);
    chk(tag, ex_if.result, exp);
    step();
  endtask

  task automatic br(input string tag, input logic [2:0] c,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic exp);
    clr();
    ex_if.is_branch = 1'b1;
    ex_if.cmp_op_in = c;
    ex_if.rs1_in    = a;
    ex_if.rs2_in    = b;
    issue();
    chk(tag, ex_if.br_en, exp);
    step();
  endtask

  initial begin
    int seen;
    clr();
    reset = 1'b0;
    step();
    step();
    chk("rst_valid", ex_if.out_valid, 0);
    chk("rst_busy", ex_if.busy, 0);
    chk("rst_res", ex_if.result, 0);
    chk("rst_rdy", ex_if.in_ready, 1);
    reset = 1'b1;
    step();

    clr();
    ex_if.rs1_in = 5;
    ex_if.rs2_in = 7;
    issue();
    chk("add_v", ex_if.out_valid, 1);
    chk("add", ex_if.result, 12);
    chk("add_br", ex_if.br_en, 0);
    step();
    chk("add_idle", ex_if.out_valid, 0);

    alu("sll", 5'd2, 32'h1, 32'd33, 32'h2);
    alu("sra", 5'd7, 32'h8000_0000, 32'd4, 32'hF800_0000);
    alu("srl", 5'd6, 32'h8000_0000, 32'd4, 32'h0800_0000);
    alu("slt", 5'd3, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu("sltu", 5'd4, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu("xor", 5'd5, 32'hF0F0, 32'h0FF0, 32'hFF00);
    alu("bad_op", 5'd11, 32'd9, 32'd9, 32'd0);

    clr();
    ex_if.op_in     = 5'd1;
    ex_if.fwd_sel_a = 3'd2;
    ex_if.fwd_data[32 +: 32] = 32'h100;
    ex_if.use_imm_b = 1'b1;
    ex_if.imm_in    = 32'd1;
    issue();
    chk("fwd_a", ex_if.result, 32'hFF);
    step();
    ex_if.fwd_sel_a = 3'd5;
    ex_if.rs1_in    = 32'h20;
    issue();
    chk("fwd_oob", ex_if.result, 32'h1F);
    step();

    clr();
    ex_if.op_in     = 5'd10;
    ex_if.fwd_sel_b = 3'd3;
    ex_if.fwd_data[64 +: 32] = 32'h55;
    ex_if.rs2_in    = 32'h99;
    issue();
    chk("fwd_b", ex_if.result, 32'h55);
    chk("rs2_fwd", ex_if.rs2_fwd, 32'h55);
    step();

    md("mulh", 5'd17, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    md("mulhu", 5'd19, 32'hFFFF_FFFF, 32'd2, 32'd1);
    md("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    md("mul", 5'd16, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
    md("div", 5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    md("rem", 5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    md("divu", 5'd21, 32'd100, 32'd7, 32'd14);
    md("remu", 5'd23, 32'd100, 32'd7, 32'd2);

    alu("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    alu("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    alu("divu_z", 5'd21, 32'd7, 32'd0, 32'hFFFF_FFFF);
    alu("rem_z", 5'd22, 32'd7, 32'd0, 32'd7);

    clr();
    ex_if.out_ready = 1'b0;
    ex_if.is_branch = 1'b1;
    ex_if.cmp_op_in = 3'd4;
    ex_if.rs1_in    = 32'hFFFF_FFFF;
    ex_if.rs2_in    = 32'd1;
    ex_if.use_pc_a  = 1'b1;
    ex_if.use_imm_b = 1'b1;
    ex_if.pc_in     = 32'h40;
    ex_if.imm_in    = 32'h10;
    issue();
    chk("blt", ex_if.br_en, 1);
    chk("br_tgt", ex_if.br_target, 32'h50);
    clr();
    ex_if.out_ready = 1'b0;
    ex_if.rs1_in    = 32'd1;
    ex_if.rs2_in    = 32'd1;
    ex_if.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_v", ex_if.out_valid, 1);
      chk("hold_tgt", ex_if.br_target, 32'h50);
      chk("hold_br", ex_if.br_en, 1);
      chk("hold_res", ex_if.result, 32'h50);
      chk("hold_rdy", ex_if.in_ready, 0);
    end
    ex_if.out_ready = 1'b1;
    step();
    ex_if.in_valid = 1'b0;
    chk("b2b_v", ex_if.out_valid, 1);
    chk("b2b_res", ex_if.result, 32'd2);
    chk("b2b_br", ex_if.br_en, 0);
    step();

    br("bge", 3'd5, 32'hFFFF_FFFF, 32'd1, 1'b0);
    br("bltu", 3'd6, 32'hFFFF_FFFF, 32'd1, 1'b0);
    br("bgeu", 3'd7, 32'hFFFF_FFFF, 32'd1, 1'b1);
    br("beq", 3'd0, 32'd3, 32'd3, 1'b1);
    br("bne", 3'd1, 32'd3, 32'd3, 1'b0);
    br("bcode2", 3'd2, 32'd3, 32'd3, 1'b0);
    clr();
    ex_if.is_jump = 1'b1;
    issue();
    chk("jump", ex_if.br_en, 1);
    step();

    clr();
    ex_if.flush    = 1'b1;
    ex_if.rs1_in   = 32'd4;
    issue();
    ex_if.flush = 1'b0;
    chk("flush_in_v", ex_if.out_valid, 0);
    chk("flush_in_res", ex_if.result, 32'd0);

    clr();
    ex_if.out_ready = 1'b0;
    ex_if.rs1_in    = 32'd3;
    issue();
    chk("fdone_pre", ex_if.out_valid, 1);
    ex_if.flush = 1'b1;
    step();
    ex_if.flush = 1'b0;
    chk("fdone_v", ex_if.out_valid, 0);
    chk("fdone_rdy", ex_if.in_ready, 1);

    clr();
    ex_if.op_in  = 5'd21;
    ex_if.rs1_in = 32'd100;
    ex_if.rs2_in = 32'd7;
    issue();
    repeat (10) step();
    chk("fmd_busy", ex_if.busy, 1);
    ex_if.flush = 1'b1;
    step();
    ex_if.flush = 1'b0;
    chk("fmd_v", ex_if.out_valid, 0);
    chk("fmd_busy0", ex_if.busy, 0);
    chk("fmd_rdy", ex_if.in_ready, 1);
    seen = 0;
    repeat (40) begin
      step();
      if (ex_if.out_valid) seen++;
    end
    chk("fmd_late", seen, 0);

    clr();
    ex_if.op_in     = 5'd21;
    ex_if.rs1_in    = 32'd100;
    ex_if.rs2_in    = 32'd7;
    ex_if.pc_in     = 32'h40;
    ex_if.imm_in    = 32'h10;
    issue();
    chk("rmd_tgt", ex_if.br_target, 32'h50);
    repeat (10) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rmd_v", ex_if.out_valid, 0);
    chk("rmd_busy", ex_if.busy, 0);
    chk("rmd_res", ex_if.result, 0);
    chk("rmd_tgt0", ex_if.br_target, 0);
    chk("rmd_st", ex_if.rs2_fwd, 0);
    chk("rmd_br", ex_if.br_en, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
